collision_pair_scheduler: RTL and testbench
===========================================

# collision_pair_scheduler

Sequencer that walks every unordered sprite pair (i<j) and issues one pairwise collision test per pair to a single shared pair-test datapath (distance-squared vs. radius-sum-squared unit). It collects the hit results into a symmetric collision matrix for the collision handler. The shared datapath therefore replaces the fully unrolled SPRITES² comparator array. The block sits between the frame controller, which pulses `start` once per physics step, and the collision handler, which consumes `collision` once `done` pulses.

## Interface
- `SPRITES`, 9, number of sprites; valid range 1..16.
- `IDX_W`, 4, width of a sprite index; must satisfy 2^IDX_W ≥ SPRITES.
- `CNT_W`, 8, width of `hit_count`; must hold SPRITES*(SPRITES-1)/2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a scan; honoured only in IDLE.
- `busy`  out  1  high in ISSUE and WAIT.
- `done`  out  1  single-cycle pulse; scan complete and `collision`/`hit_count` valid.
- `req_valid`  out  1  pair request to the shared datapath.
- `req_ready`  in  1  datapath accepts a request.
- `req_i`  out  IDX_W  first sprite index of the pair (lower index).
- `req_j`  out  IDX_W  second sprite index of the pair (higher index).
- `resp_valid`  in  1  datapath result strobe.
- `resp_hit`  in  1  1 = pair overlaps; qualified by `resp_valid`.
- `collision`  out  SPRITES×SPRITES  registered matrix `[SPRITES-1:0][SPRITES-1:0]`, symmetric, diagonal always 0.
- `hit_count`  out  CNT_W  number of colliding unordered pairs in the last scan.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `start`=1 clears `collision` and `hit_count` and loads i=0, j=1.
  - Next state is ISSUE, or DONE if SPRITES<2.
- **ISSUE**
  - `req_valid`=1, with `req_i`/`req_j` driven from the pair registers.
  - Indices are held stable until `req_valid && req_ready`, then the block goes to WAIT.
- **WAIT**
  - `req_valid`=0. Exactly one request is outstanding at a time.
  - On `resp_valid`, `collision[i][j]` and `collision[j][i]` are written with `resp_hit`, and `hit_count` increments if `resp_hit`=1.
  - The pair then advances:
    - If j<SPRITES-1: j←j+1.
    - Otherwise i←i+1 and j←i+2, using the old i.
    - If the completed pair was (SPRITES-2, SPRITES-1), go to DONE; otherwise go to ISSUE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- Pair order is row-major over the upper triangle: (0,1),(0,2)…(0,S-1),(1,2)…(S-2,S-1). Total pairs = S(S-1)/2, which is 36 for S=9.
- `start` outside IDLE is ignored. No queuing and no restart.
- `resp_valid` outside WAIT is ignored and does not alter state or outputs.
- `resp_valid` asserted in the same cycle as the ISSUE handshake is not accepted. A response is valid no earlier than the cycle after acceptance.
- `collision` and `hit_count` hold their values after DONE until the next accepted `start`.
- Diagonal entries are never written.
- `hit_count` is not saturated, because its width is sized by parameter.

## Timing
- Reset (async assert, released synchronously to `clk`):
  - state=IDLE.
  - `busy`, `done`, `req_valid` = 0.
  - `req_i`, `req_j`, `collision`, `hit_count` = 0.
- `rst_n` low mid-scan aborts immediately to the reset values. The next scan requires a new `start`.
- All outputs are registered or decoded directly from state registers. There is no combinational path from `req_ready`, `resp_valid` or `resp_hit` to any output.
- Start latency: `start` sampled at edge T, so `busy`=1 and `req_valid`=1 from cycle T+1.
- Per pair: 1 ISSUE cycle (plus stall cycles while `req_ready`=0), then WAIT cycles until the response.
- With `req_ready`=1 and 1-cycle response latency:
  - Each pair takes 2 cycles.
  - For S=9, the last response is in cycle 72 after `start`, `done` in cycle 73, and IDLE in cycle 74.
- A new `start` is accepted in the cycle after `done` (IDLE).

## Test plan
- **Reset values**: assert `rst_n`=0 with `start`=1 held → all outputs 0 and `start` ignored; release → IDLE with `busy`=0.
- **Full scan, S=9, no hits**:
  - Stimulus: `req_ready`=1, response 1 cycle after accept, `resp_hit`=0.
  - Required: 36 requests in row-major order (0,1)…(7,8); `done` at cycle 73; `collision`=0; `hit_count`=0.
- **Selected hits, S=9**:
  - Stimulus: hits on (0,3), (2,8), (7,8).
  - Required: those six matrix bits set (both orientations), diagonal 0, `hit_count`=3.
- **Backpressure and latency**:
  - Stimulus: `req_ready` low for 3 cycles per request, response latency 5 cycles.
  - Required: `req_i`/`req_j` stable while stalled; `done` at cycle 36×(4+5)+1=325.
- **Spurious events**:
  - Stimulus: `resp_valid` pulsed in ISSUE and in IDLE; `start` pulsed mid-scan.
  - Required: no matrix or count change and no restart; final result identical to the undisturbed run.
- **Abort and small configurations**:
  - Stimulus: `rst_n` pulsed low during pair (3,5).
  - Required: outputs return to 0; a fresh `start` completes normally.
  - S=2 build → a single pair (0,1), then `done`.
  - S=1 build → `done` one cycle after `start`, with no request issued.

Source files
------------

// File: rtl/collision_pair_scheduler.sv
// Walks every unordered sprite pair (i<j) through one shared pair-test datapath
// and collects the hit results into a symmetric collision matrix and hit count.
module collision_pair_scheduler #(
  parameter int SPRITES = 9,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              req_valid,
  input  logic                              req_ready,
  output logic [IDX_W-1:0]                  req_i,
  output logic [IDX_W-1:0]                  req_j,
  input  logic                              resp_valid,
  input  logic                              resp_hit,
  output logic [SPRITES-1:0][SPRITES-1:0]   collision,
  output logic [CNT_W-1:0]                  hit_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Indices of the final pair (S-2, S-1); clamped so S=1 builds stay legal.
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'((SPRITES >= 2) ? SPRITES - 2 : 0);
  localparam logic [IDX_W-1:0] LAST_J = IDX_W'((SPRITES >= 2) ? SPRITES - 1 : 0);

  logic [1:0] state;
  logic       accept_resp;

  assign accept_resp = (state == WAIT) && resp_valid;
  assign busy        = (state == ISSUE) || (state == WAIT);
  assign done        = (state == DONE);
  assign req_valid   = (state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_i     <= '0;
      req_j     <= '0;
      hit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req_i     <= '0;
            req_j     <= IDX_W'(1);
            hit_count <= '0;
            state     <= (SPRITES < 2) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (resp_valid) begin
            if (resp_hit) begin
              hit_count <= hit_count + CNT_W'(1);
            end
            // Row-major walk of the upper triangle: next column, else next row.
            if (req_j < LAST_J) begin
              req_j <= req_j + IDX_W'(1);
            end else begin
              req_i <= req_i + IDX_W'(1);
              req_j <= req_i + IDX_W'(2);
            end
            state <= ((req_i == LAST_I) && (req_j == LAST_J)) ? DONE : ISSUE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Mirror each result into both halves; the diagonal is never addressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= '0;
    end else if ((state == IDLE) && start) begin
      collision <= '0;
    end else if (accept_resp) begin
      for (int r = 0; r < SPRITES; r++) begin
        for (int c = 0; c < SPRITES; c++) begin
          if ((r != c) &&
              (((req_i == IDX_W'(r)) && (req_j == IDX_W'(c))) ||
               ((req_i == IDX_W'(c)) && (req_j == IDX_W'(r))))) begin
            collision[r][c] <= resp_hit;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Randomised self-checking bench for collision_pair_scheduler against a pair-list
// and hit-matrix reference model; also covers the S=2 and S=1 builds.
module tb_collision_pair_scheduler;

  localparam int S  = 9;
  localparam int IW = 4;
  localparam int CW = 8;

  typedef struct {
    int i;
    int j;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, start, req_ready, resp_valid, resp_hit;
  logic                  busy, done, req_valid;
  logic [IW-1:0]         req_i, req_j;
  logic [S-1:0][S-1:0]   collision;
  logic [CW-1:0]         hit_count;

  logic                  start2, ready2, rv2, rh2, busy2, done2, rq2;
  logic [IW-1:0]         ri2, rj2;
  logic [1:0][1:0]       col2;
  logic [CW-1:0]         hc2;

  logic                  start1, quiet1, busy1, done1, rq1;
  logic [IW-1:0]         ri1, rj1;
  logic [0:0][0:0]       col1;
  logic [CW-1:0]         hc1;

  collision_pair_scheduler #(.SPRITES(S), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .req_i(req_i), .req_j(req_j),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .collision(collision),
    .hit_count(hit_count)
  );

  collision_pair_scheduler #(.SPRITES(2), .IDX_W(IW), .CNT_W(CW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .req_valid(rq2), .req_ready(ready2), .req_i(ri2), .req_j(rj2),
    .resp_valid(rv2), .resp_hit(rh2), .collision(col2), .hit_count(hc2)
  );

  collision_pair_scheduler #(.SPRITES(1), .IDX_W(IW), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .req_valid(rq1), .req_ready(quiet1), .req_i(ri1), .req_j(rj1),
    .resp_valid(quiet1), .resp_hit(quiet1), .collision(col1), .hit_count(hc1)
  );

  int    n_pass = 0;
  int    n_checks = 0;
  int    cycle;
  bit    exp_hit[S][S];
  pair_t pairs[$];

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  function automatic logic [127:0] expVec();
    logic [127:0] v = '0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        v[r*S+c] = exp_hit[r][c];
    return v;
  endfunction

  function automatic int expCount();
    int n = 0;
    foreach (pairs[k]) n += int'(exp_hit[pairs[k].i][pairs[k].j]);
    return n;
  endfunction

  task automatic setHit(input int a, input int b, input bit h);
    exp_hit[a][b] = h;
    exp_hit[b][a] = h;
  endtask

  task automatic clearHits();
    foreach (pairs[k]) setHit(pairs[k].i, pairs[k].j, 1'b0);
  endtask

  task automatic randomHits();
    foreach (pairs[k]) setHit(pairs[k].i, pairs[k].j, ($urandom_range(0, 3) == 0));
  endtask

  // Plays the datapath for one scan; abort_k >= 0 pulls rst_n low after that pair's accept.
  task automatic applyStimulus(input int stall, input int lat, input bit spurious, input int abort_k);
    int pi, pj;
    cycle = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (pairs[k]) begin
      pi = pairs[k].i;
      pj = pairs[k].j;
      for (int s = 0; s <= stall; s++) begin
        checkOutput("issue_req_valid", req_valid, 1);
        checkOutput("issue_req_i", req_i, pi);
        checkOutput("issue_req_j", req_j, pj);
        req_ready = (s == stall);
        if (spurious) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          if (k == 4 && s == 0) start = 1'b1;
        end
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        start      = 1'b0;
      end
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_req_valid", req_valid, 0);
        checkOutput("abort_req_i", req_i, 0);
        checkOutput("abort_req_j", req_j, 0);
        checkOutput("abort_collision", collision, 0);
        checkOutput("abort_hit_count", hit_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("abort_idle_busy", busy, 0);
        return;
      end
      for (int w = 1; w < lat; w++) begin
        checkOutput("wait_req_valid", req_valid, 0);
        checkOutput("wait_busy", busy, 1);
        tick();
      end
      resp_valid = 1'b1;
      resp_hit   = exp_hit[pi][pj];
      tick();
      resp_valid = 1'b0;
      resp_hit   = 1'b0;
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("done_cycle", cycle, pairs.size() * (stall + 1 + lat) + 1);
    checkOutput("collision", collision, expVec());
    checkOutput("hit_count", hit_count, expCount());
    tick();
    checkOutput("done_single", done, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  initial begin
    int abort_k;
    int st, la;
    for (int i = 0; i < S; i++)
      for (int j = i + 1; j < S; j++)
        pairs.push_back('{i, j});

    rst_n = 1'b0; start = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0;
    start2 = 1'b0; ready2 = 1'b0; rv2 = 1'b0; rh2 = 1'b0; start1 = 1'b0; quiet1 = 1'b0;
    cycle = 0;
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_req_valid", req_valid, 0);
    checkOutput("rst_req_ij", {req_i, req_j}, 0);
    checkOutput("rst_collision", collision, 0);
    checkOutput("rst_hit_count", hit_count, 0);
    checkOutput("rst_s2_busy", busy2, 0);
    checkOutput("rst_s1_done", done1, 0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    tick();
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_req_valid", req_valid, 0);

    $display("[TB] full scan, no hits");
    clearHits();
    applyStimulus(0, 1, 1'b0, -1);

    $display("[TB] selected hits");
    setHit(0, 3, 1'b1);
    setHit(2, 8, 1'b1);
    setHit(7, 8, 1'b1);
    applyStimulus(0, 1, 1'b0, -1);
    resp_valid = 1'b1;
    resp_hit   = 1'b1;
    tick();
    tick();
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    checkOutput("idle_resp_collision", collision, expVec());
    checkOutput("idle_resp_hit_count", hit_count, 3);
    checkOutput("idle_resp_busy", busy, 0);

    $display("[TB] backpressure and latency");
    randomHits();
    applyStimulus(3, 5, 1'b0, -1);

    $display("[TB] spurious events");
    applyStimulus(1, 2, 1'b1, -1);
    applyStimulus(0, 1, 1'b1, -1);

    $display("[TB] random timing");
    st = $urandom_range(0, 2);
    la = $urandom_range(1, 4);
    randomHits();
    applyStimulus(st, la, 1'b0, -1);

    $display("[TB] abort during pair (3,5)");
    abort_k = -1;
    foreach (pairs[k]) if (pairs[k].i == 3 && pairs[k].j == 5) abort_k = k;
    foreach (pairs[k]) setHit(pairs[k].i, pairs[k].j, 1'b1);
    applyStimulus(0, 1, 1'b0, abort_k);
    randomHits();
    applyStimulus(0, 1, 1'b0, -1);

    $display("[TB] two-sprite build");
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checkOutput("s2_req_valid", rq2, 1);
    checkOutput("s2_req_ij", {ri2, rj2}, {4'd0, 4'd1});
    checkOutput("s2_busy", busy2, 1);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    checkOutput("s2_wait_req_valid", rq2, 0);
    rv2 = 1'b1;
    rh2 = 1'b1;
    tick();
    rv2 = 1'b0;
    rh2 = 1'b0;
    checkOutput("s2_done", done2, 1);
    checkOutput("s2_collision", col2, 4'b0110);
    checkOutput("s2_hit_count", hc2, 1);
    tick();
    checkOutput("s2_done_single", done2, 0);

    $display("[TB] one-sprite build");
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("s1_done", done1, 1);
    checkOutput("s1_req_valid", rq1, 0);
    checkOutput("s1_busy", busy1, 0);
    tick();
    checkOutput("s1_done_single", done1, 0);
    checkOutput("s1_no_request", rq1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
